// File: rtl/regfile_mp_if.sv
// Register-file port bundle: write ports, read ports and status, each bus sliced per port.
// The master side (decode/writeback) drives addresses and data; the slave side is the register file.
interface regfile_mp_if #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     ready;
   logic                     wr_conflict;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  rd_data, ready, wr_conflict
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data, ready, wr_conflict
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with a post-reset clearing sweep, optional zero register and write bypass.
// Reads are registered (1 cycle), writes land at the enabling edge; no backpressure, inputs are ignored until ready.
module regfile_mp #(
   parameter int DATA_W   = 64,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  rf
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0]        mem_q [DEPTH];
   logic [DATA_W-1:0]        mem_d [DEPTH];
   logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
   logic                     conflict_q, conflict_d;
   logic [NUM_WR-1:0]        wr_ok;

   // An address is live when it maps to real storage that accepts writes.
   function automatic logic addr_live(input logic [ADDR_W-1:0] a);
      return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   always_comb begin
      wr_ok = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         wr_ok[j] = rf.wr_en[j] && addr_live(rf.wr_addr[j*ADDR_W +: ADDR_W])
                    && (state_q == ST_RUN) && !rst;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         if (cnt_q == LAST_IDX) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + ADDR_W'(1);
         end
      end
   end

   // Later ports overwrite earlier ones, so the highest-index port wins a collision.
   always_comb begin
      mem_d = mem_q;
      if (state_q == ST_INIT) begin
         mem_d[cnt_q] = '0;
      end
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_ok[j]) begin
            mem_d[rf.wr_addr[j*ADDR_W +: ADDR_W]] = rf.wr_data[j*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      conflict_d = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
         for (int k = j + 1; k < NUM_WR; k++) begin
            if (wr_ok[j] && wr_ok[k] &&
                (rf.wr_addr[j*ADDR_W +: ADDR_W] == rf.wr_addr[k*ADDR_W +: ADDR_W])) begin
               conflict_d = 1'b1;
            end
         end
      end
   end

   always_comb begin : rd_path
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;
      rd_data_d = rd_data_q;
      ra        = '0;
      rv        = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         ra = rf.rd_addr[i*ADDR_W +: ADDR_W];
         rv = '0;
         if ((state_q == ST_RUN) && addr_live(ra)) begin
            rv = mem_q[ra];
            if (BYPASS != 0) begin
               for (int j = 0; j < NUM_WR; j++) begin
                  if (wr_ok[j] && (rf.wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
                     rv = rf.wr_data[j*DATA_W +: DATA_W];
                  end
               end
            end
         end
         if (rf.rd_en[i]) begin
            rd_data_d[i*DATA_W +: DATA_W] = rv;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         conflict_q <= conflict_d;
      end
   end

   // Storage is cleared only by the sweep, never by rst directly.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rf.rd_data     = rd_data_q;
   assign rf.ready       = (state_q == ST_RUN);
   assign rf.wr_conflict = conflict_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default (bypass) and no-bypass instances share stimulus; a DEPTH=24 instance runs random traffic.
module tb_regfile_mp;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_tests;
   int n_fail;

   regfile_mp_if #(.DATA_W(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) ifa ();
   regfile_mp_if #(.DATA_W(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) ifb ();
   regfile_mp_if #(.DATA_W(32), .DEPTH(24), .NUM_RD(4), .NUM_WR(1)) ifc ();

   regfile_mp #(.DATA_W(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1))
      u_a (.clk(clk), .rst(rst), .rf(ifa));
   regfile_mp #(.DATA_W(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0))
      u_b (.clk(clk), .rst(rst), .rf(ifb));
   regfile_mp #(.DATA_W(32), .DEPTH(24), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1), .BYPASS(1))
      u_c (.clk(clk), .rst(rst), .rf(ifc));

   assign ifb.wr_en   = ifa.wr_en;
   assign ifb.wr_addr = ifa.wr_addr;
   assign ifb.wr_data = ifa.wr_data;
   assign ifb.rd_en   = ifa.rd_en;
   assign ifb.rd_addr = ifa.rd_addr;

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [4:0]  wa1;
      logic [63:0] wd0;
      logic [63:0] wd1;
      logic [1:0]  re;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [63:0] ea0;
      logic [63:0] ea1;
      logic [63:0] eb0;
      logic        ecf;
   } vec_t;

   vec_t vecs [13];

   logic        we_c;
   logic [4:0]  wa_c;
   logic [31:0] wd_c;
   logic [3:0]  re_c;
   logic [4:0]  ra_c [4];
   logic [31:0] exp_c [4];
   logic [31:0] cmem [32];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                          input logic [63:0] wd0, input logic [63:0] wd1,
                          input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
      ifa.wr_en   = we;
      ifa.wr_addr = {wa1, wa0};
      ifa.wr_data = {wd1, wd0};
      ifa.rd_en   = re;
      ifa.rd_addr = {ra1, ra0};
   endtask

   function automatic logic [4:0] pick_addr();
      if ($urandom_range(0, 3) == 0) return 5'd30;
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      n_tests = 0;
      n_fail  = 0;

      //            we     wa0    wa1    wd0            wd1     re     ra0    ra1    ea0            ea1            eb0            cf
      vecs[0]  = '{2'b01, 5'd7,  5'd0,  64'h1,         64'h0,  2'b11, 5'd3,  5'd4,  64'h0,         64'h0,         64'h0,         1'b0};
      vecs[1]  = '{2'b01, 5'd7,  5'd0,  64'hDEADBEEF,  64'h0,  2'b11, 5'd7,  5'd7,  64'hDEADBEEF,  64'hDEADBEEF,  64'h1,         1'b0};
      vecs[2]  = '{2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  2'b01, 5'd7,  5'd0,  64'hDEADBEEF,  64'hDEADBEEF,  64'hDEADBEEF,  1'b0};
      vecs[3]  = '{2'b11, 5'd9,  5'd9,  64'h11,        64'h22, 2'b01, 5'd9,  5'd0,  64'h22,        64'hDEADBEEF,  64'h0,         1'b1};
      vecs[4]  = '{2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  2'b11, 5'd9,  5'd9,  64'h22,        64'h22,        64'h22,        1'b0};
      vecs[5]  = '{2'b11, 5'd0,  5'd0,  64'hFF,        64'hEE, 2'b11, 5'd0,  5'd9,  64'h0,         64'h22,        64'h0,         1'b0};
      vecs[6]  = '{2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  2'b01, 5'd0,  5'd0,  64'h0,         64'h22,        64'h0,         1'b0};
      vecs[7]  = '{2'b01, 5'd0,  5'd0,  64'hFF,        64'h0,  2'b00, 5'd9,  5'd7,  64'h0,         64'h22,        64'h0,         1'b0};
      vecs[8]  = '{2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  2'b11, 5'd0,  5'd7,  64'h0,         64'hDEADBEEF,  64'h0,         1'b0};
      vecs[9]  = '{2'b11, 5'd12, 5'd13, 64'hA5,        64'h5A, 2'b11, 5'd13, 5'd12, 64'h5A,        64'hA5,        64'h0,         1'b0};
      vecs[10] = '{2'b10, 5'd0,  5'd12, 64'h0,         64'hC3, 2'b11, 5'd12, 5'd13, 64'hC3,        64'h5A,        64'hA5,        1'b0};
      vecs[11] = '{2'b11, 5'd31, 5'd30, 64'h77,        64'h66, 2'b11, 5'd31, 5'd30, 64'h77,        64'h66,        64'h0,         1'b0};
      vecs[12] = '{2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  2'b11, 5'd30, 5'd31, 64'h66,        64'h77,        64'h66,        1'b0};

      rst = 1'b1;
      drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00, 5'd0, 5'd0);
      ifc.wr_en   = '0;
      ifc.wr_addr = '0;
      ifc.wr_data = '0;
      ifc.rd_en   = '0;
      ifc.rd_addr = '0;
      repeat (3) tick();

      check("reset rd_data_a", 64'(ifa.rd_data[127:64] | ifa.rd_data[63:0]), 64'h0);
      check("reset ready_a", 64'(ifa.ready), 64'h0);
      check("reset conflict_a", 64'(ifa.wr_conflict), 64'h0);
      check("reset ready_c", 64'(ifc.ready), 64'h0);

      // Sweep: write to r5 during INIT must be dropped.
      rst = 1'b0;
      drive_a(2'b01, 5'd5, 5'd0, 64'hAA, 64'h0, 2'b00, 5'd0, 5'd0);
      for (int n = 1; n <= 32; n++) begin
         tick();
         if (n == 1) drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00, 5'd0, 5'd0);
         check($sformatf("sweep ready_a edge%0d", n), 64'(ifa.ready), 64'(n == 32));
         check($sformatf("sweep ready_c edge%0d", n), 64'(ifc.ready), 64'(n >= 24));
      end

      for (int a = 0; a < 32; a++) begin
         drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b11, 5'(a), 5'(31 - a));
         tick();
         check($sformatf("clear p0 r%0d", a), ifa.rd_data[63:0], 64'h0);
         check($sformatf("clear p1 r%0d", 31 - a), ifa.rd_data[127:64], 64'h0);
      end

      for (int v = 0; v < 13; v++) begin
         drive_a(vecs[v].we, vecs[v].wa0, vecs[v].wa1, vecs[v].wd0, vecs[v].wd1,
                 vecs[v].re, vecs[v].ra0, vecs[v].ra1);
         tick();
         check($sformatf("vec%0d rd0_a", v), ifa.rd_data[63:0], vecs[v].ea0);
         check($sformatf("vec%0d rd1_a", v), ifa.rd_data[127:64], vecs[v].ea1);
         check($sformatf("vec%0d rd0_b", v), ifb.rd_data[63:0], vecs[v].eb0);
         check($sformatf("vec%0d conflict_a", v), 64'(ifa.wr_conflict), 64'(vecs[v].ecf));
         check($sformatf("vec%0d conflict_b", v), 64'(ifb.wr_conflict), 64'(vecs[v].ecf));
      end

      // Reset mid-sweep with r20 preloaded.
      drive_a(2'b01, 5'd20, 5'd0, 64'h1234, 64'h0, 2'b00, 5'd0, 5'd0);
      tick();
      drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b01, 5'd20, 5'd0);
      tick();
      check("preload r20 a", ifa.rd_data[63:0], 64'h1234);
      check("preload r20 b", ifb.rd_data[63:0], 64'h1234);
      drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00, 5'd0, 5'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         check($sformatf("partial sweep ready edge%0d", n), 64'(ifa.ready), 64'h0);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 1; n <= 32; n++) begin
         tick();
         check($sformatf("restart ready_a edge%0d", n), 64'(ifa.ready), 64'(n == 32));
      end
      drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b11, 5'd20, 5'd7);
      tick();
      check("restart r20 a", ifa.rd_data[63:0], 64'h0);
      check("restart r7 a", ifa.rd_data[127:64], 64'h0);
      check("restart r20 b", ifb.rd_data[63:0], 64'h0);
      drive_a(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00, 5'd0, 5'd0);

      // Random traffic on the DEPTH=24 instance against a plain array model.
      check("ready_c before random", 64'(ifc.ready), 64'h1);
      for (int i = 0; i < 32; i++) cmem[i] = '0;
      for (int i = 0; i < 4; i++) exp_c[i] = '0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         we_c = 1'($urandom_range(0, 1));
         wa_c = pick_addr();
         wd_c = $urandom();
         re_c = (cyc == 0) ? 4'hF : 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) begin
            ra_c[i] = pick_addr();
            if (re_c[i]) begin
               if (ra_c[i] >= 5'd24 || ra_c[i] == 5'd0) exp_c[i] = '0;
               else if (we_c && wa_c == ra_c[i])        exp_c[i] = wd_c;
               else                                      exp_c[i] = cmem[ra_c[i]];
            end
         end
         ifc.wr_en   = we_c;
         ifc.wr_addr = wa_c;
         ifc.wr_data = wd_c;
         ifc.rd_en   = re_c;
         ifc.rd_addr = {ra_c[3], ra_c[2], ra_c[1], ra_c[0]};
         tick();
         for (int i = 0; i < 4; i++) begin
            check($sformatf("rand cyc%0d port%0d", cyc, i), 64'(ifc.rd_data[i*32 +: 32]), 64'(exp_c[i]));
         end
         check($sformatf("rand cyc%0d conflict", cyc), 64'(ifc.wr_conflict), 64'h0);
         if (we_c && wa_c < 5'd24 && wa_c != 5'd0) cmem[wa_c] = wd_c;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
